encoder_frontend: RTL



---
 rtl/encoder_frontend.sv | 138 +++++++++++++
 1 files changed

// File: rtl/encoder_frontend.sv
// rtl/encoder_frontend.sv - quadrature encoder synchroniser, debouncer and wrapping channel counter
//
// Purpose: turns one rotary encoder's raw A/B pins into a WIDTH-bit channel
// value that feeds a PWM level input. The pins are synchronised, then
// debounced on a prescaled sample tick. Direction is decoded on both edges
// of debounced A, and the result steps a wrapping counter.
//
// Ports:
//   wb_clk_i   - single clock
//   wb_rst_i   - synchronous active-high reset
//   active     - block enable; decoder events are dropped while low
//   enc_a      - raw encoder A pin (asynchronous)
//   enc_b      - raw encoder B pin (asynchronous)
//   load       - synchronous preload strobe, has priority over steps
//   load_value - value written by load
//   value      - channel value (registered)
//   step       - one-cycle pulse when value takes a count step
//   dir        - direction of the last step, 1 = up, 0 = down
module encoder_frontend #(
  parameter int WIDTH  = 8,
  parameter int DB_DIV = 256,
  parameter int DB_LEN = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             active,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir
);

  localparam int PW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DB_DIV - 1);

  // Two-flop synchronisers, always running regardless of active.
  logic a_s1, a_s2, b_s1, b_s2;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= enc_a;
      a_s2 <= a_s1;
      b_s1 <= enc_b;
      b_s2 <= b_s1;
    end
  end

  // Sample prescaler. With DB_DIV=1 the counter is stuck at 0, which equals
  // PRE_LAST, so tick is high every cycle.
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Debounce: the window is the stored history plus the current synced
  // sample, so a level is accepted on the DB_LEN-th consecutive equal tick.
  logic [DB_LEN-2:0] hist_a, hist_b;
  logic [DB_LEN-1:0] win_a, win_b;
  logic              da, db;

  assign win_a = {hist_a, a_s2};
  assign win_b = {hist_b, b_s2};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hist_a <= '0;
      hist_b <= '0;
      da     <= 1'b0;
      db     <= 1'b0;
    end else if (tick) begin
      if (&win_a) begin
        da <= 1'b1;
      end else if (~|win_a) begin
        da <= 1'b0;
      end
      if (&win_b) begin
        db <= 1'b1;
      end else if (~|win_b) begin
        db <= 1'b0;
      end
      hist_a <= win_a[DB_LEN-2:0];
      hist_b <= win_b[DB_LEN-2:0];
    end
  end

  // Decoder: either edge of debounced A is an event. da_prev tracks da
  // unconditionally so an event dropped while inactive is never replayed.
  logic da_prev;
  logic enc_event;
  logic enc_up;

  assign enc_event = da ^ da_prev;
  assign enc_up    = da ^ db;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      da_prev <= 1'b0;
    end else begin
      da_prev <= da;
    end
  end

  // Counter: reset, then load, then event. An event coinciding with load
  // is discarded rather than deferred.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      value <= '0;
      step  <= 1'b0;
      dir   <= 1'b0;
    end else if (load) begin
      value <= load_value;
      step  <= 1'b0;
    end else if (enc_event && active) begin
      value <= enc_up ? value + WIDTH'(1) : value - WIDTH'(1);
      step  <= 1'b1;
      dir   <= enc_up;
    end else begin
      step  <= 1'b0;
    end
  end

endmodule
